bus_rr_xbar: RTL and testbench

BUS_RR_XBAR -- requirements
Module: bus_rr_xbar

---
 rtl/bus_rr_xbar_if.sv | 41 ++++
 rtl/bus_rr_xbar.sv | 180 ++++++++++++++++++
 tb/tb_bus_rr_xbar.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bus_rr_xbar_if.sv
// Host/device bus bundle for bus_rr_xbar. The slave modport is the crossbar side;
// the master modport is the side that drives host requests and device responses.
interface bus_rr_xbar_if #(
  parameter int NrHosts      = 3,
  parameter int NrDevices    = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic                    host_req_i     [NrHosts];
  logic                    host_gnt_o     [NrHosts];
  logic [AddressWidth-1:0] host_addr_i    [NrHosts];
  logic                    host_we_i      [NrHosts];
  logic [DataWidth/8-1:0]  host_be_i      [NrHosts];
  logic [DataWidth-1:0]    host_wdata_i   [NrHosts];
  logic                    host_rvalid_o  [NrHosts];
  logic [DataWidth-1:0]    host_rdata_o   [NrHosts];
  logic                    host_err_o     [NrHosts];

  logic                    device_req_o    [NrDevices];
  logic [AddressWidth-1:0] device_addr_o   [NrDevices];
  logic                    device_we_o     [NrDevices];
  logic [DataWidth/8-1:0]  device_be_o     [NrDevices];
  logic [DataWidth-1:0]    device_wdata_o  [NrDevices];
  logic                    device_rvalid_i [NrDevices];
  logic [DataWidth-1:0]    device_rdata_i  [NrDevices];
  logic                    device_err_i    [NrDevices];

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_rdata_i, device_err_i
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  device_req_o, device_addr_o, device_we_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_rdata_i, device_err_i
  );
endinterface

// File: rtl/bus_rr_xbar.sv
// N-host / M-device crossbar with in-order response tracking FIFO and address decode.
// Define BUS_RR_XBAR_RR_ARB_EN for round-robin arbitration; otherwise fixed priority.

module bus_rr_xbar_dec #(
  parameter int NrDevices    = 2,
  parameter int AddressWidth = 32,
  parameter int DIW          = 1
) (
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [AddressWidth-1:0] base_i [NrDevices],
  input  logic [AddressWidth-1:0] mask_i [NrDevices],
  output logic [DIW-1:0]          dev_o,
  output logic                    miss_o
);
  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    dev_o  = '0;
    miss_o = 1'b1;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((addr_i & mask_i[d]) == base_i[d]) begin
        dev_o  = DIW'(d);
        miss_o = 1'b0;
      end
    end
  end
endmodule

module bus_rr_xbar #(
  parameter int NrHosts        = 3,
  parameter int NrDevices      = 2,
  parameter int DataWidth      = 32,
  parameter int AddressWidth   = 32,
  parameter int MaxOutstanding = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  bus_rr_xbar_if.slave                      bus,
  input  logic [AddressWidth-1:0]           cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]           cfg_device_addr_mask [NrDevices],
  output logic [$clog2(MaxOutstanding):0]   outstanding_o,
  output logic                              protocol_err_o
);
  localparam int HIW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DIW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int PW  = $clog2(MaxOutstanding);
  localparam int OW  = PW + 1;

  typedef struct packed {
    logic [HIW-1:0] host;
    logic [DIW-1:0] dev;
    logic           dec_err;
  } entry_t;

  logic [DIW-1:0] hdev  [NrHosts];
  logic           hmiss [NrHosts];

  for (genvar h = 0; h < NrHosts; h++) begin : g_dec
    bus_rr_xbar_dec #(.NrDevices(NrDevices), .AddressWidth(AddressWidth), .DIW(DIW)) u_dec (
      .addr_i (bus.host_addr_i[h]),
      .base_i (cfg_device_addr_base),
      .mask_i (cfg_device_addr_mask),
      .dev_o  (hdev[h]),
      .miss_o (hmiss[h])
    );
  end

  entry_t         fifo_q [MaxOutstanding];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]  cnt_q, cnt_d;
  logic           perr_q, perr_d;
  entry_t         head, push_e;
  logic           empty, full, pop, viol, can_grant;
  logic           gnt_vld;
  logic [HIW-1:0] gnt_idx;

  // Retirement: decode-error heads retire immediately, others wait for their device.
  always_comb begin
    head      = fifo_q[rd_ptr_q];
    empty     = (cnt_q == '0);
    full      = (cnt_q == OW'(MaxOutstanding));
    pop       = 1'b0;
    viol      = 1'b0;
    if (!empty) pop = head.dec_err | bus.device_rvalid_i[head.dev];
    for (int d = 0; d < NrDevices; d++) begin
      if (bus.device_rvalid_i[d] && (empty || head.dec_err || int'(head.dev) != d)) viol = 1'b1;
    end
    if (rst_i) begin
      pop  = 1'b0;
      viol = 1'b0;
    end
    can_grant = !rst_i && (!full || pop);
  end

`ifdef BUS_RR_XBAR_RR_ARB_EN
  logic [HIW-1:0] ptr_q, ptr_d;
  int             rr_j;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_j    = 0;
    for (int i = 0; i < NrHosts; i++) begin
      rr_j = int'(ptr_q) + i;
      if (rr_j >= NrHosts) rr_j = rr_j - NrHosts;
      if (!gnt_vld && bus.host_req_i[rr_j]) begin
        gnt_vld = 1'b1;
        gnt_idx = HIW'(rr_j);
      end
    end
    if (!can_grant) gnt_vld = 1'b0;
    ptr_d = ptr_q;
    if (gnt_vld) ptr_d = (int'(gnt_idx) == NrHosts - 1) ? '0 : HIW'(int'(gnt_idx) + 1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NrHosts; i++) begin
      if (!gnt_vld && bus.host_req_i[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = HIW'(i);
      end
    end
    if (!can_grant) gnt_vld = 1'b0;
  end
`endif

  always_comb begin
    push_e   = '{host: gnt_idx, dev: hdev[gnt_idx], dec_err: hmiss[gnt_idx]};
    wr_ptr_d = wr_ptr_q + PW'(gnt_vld);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + OW'(gnt_vld) - OW'(pop);
    perr_d   = perr_q | viol;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt_vld) fifo_q[wr_ptr_q] <= push_e;
  end

  always_comb begin
    for (int h = 0; h < NrHosts; h++) begin
      bus.host_gnt_o[h]    = gnt_vld && (gnt_idx == HIW'(h));
      bus.host_rvalid_o[h] = pop && (head.host == HIW'(h));
      bus.host_rdata_o[h]  = (bus.host_rvalid_o[h] && !head.dec_err) ? bus.device_rdata_i[head.dev] : '0;
      bus.host_err_o[h]    = bus.host_rvalid_o[h] && (head.dec_err || bus.device_err_i[head.dev]);
    end
  end

  always_comb begin
    for (int d = 0; d < NrDevices; d++) begin
      bus.device_req_o[d]   = gnt_vld && !hmiss[gnt_idx] && (int'(hdev[gnt_idx]) == d);
      bus.device_addr_o[d]  = bus.device_req_o[d] ? bus.host_addr_i[gnt_idx]  : '0;
      bus.device_we_o[d]    = bus.device_req_o[d] && bus.host_we_i[gnt_idx];
      bus.device_be_o[d]    = bus.device_req_o[d] ? bus.host_be_i[gnt_idx]    : '0;
      bus.device_wdata_o[d] = bus.device_req_o[d] ? bus.host_wdata_i[gnt_idx] : '0;
    end
  end

  assign outstanding_o  = cnt_q;
  assign protocol_err_o = perr_q;
endmodule

// File: tb/tb_bus_rr_xbar.sv
// Directed bench for bus_rr_xbar: arbitration, decode error, FIFO full, protocol error, reset.
module tb_bus_rr_xbar;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] base [2];
  logic [31:0] mask [2];
  logic [2:0]  outstanding;
  logic        perr;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk_i = ~clk_i;

  bus_rr_xbar_if #(.NrHosts(3), .NrDevices(2), .DataWidth(32), .AddressWidth(32)) bus ();

  bus_rr_xbar #(.NrHosts(3), .NrDevices(2), .DataWidth(32), .AddressWidth(32), .MaxOutstanding(4)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .bus                  (bus),
    .cfg_device_addr_base (base),
    .cfg_device_addr_mask (mask),
    .outstanding_o        (outstanding),
    .protocol_err_o       (perr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] gnt_v();
    for (int i = 0; i < 3; i++) gnt_v[i] = bus.host_gnt_o[i];
  endfunction
  function automatic logic [2:0] rv_v();
    for (int i = 0; i < 3; i++) rv_v[i] = bus.host_rvalid_o[i];
  endfunction
  function automatic logic [1:0] dreq_v();
    for (int i = 0; i < 2; i++) dreq_v[i] = bus.device_req_o[i];
  endfunction

  task automatic idle();
    for (int h = 0; h < 3; h++) begin
      bus.host_req_i[h] = 1'b0; bus.host_addr_i[h] = '0; bus.host_we_i[h] = 1'b0;
      bus.host_be_i[h] = '0; bus.host_wdata_i[h] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      bus.device_rvalid_i[d] = 1'b0; bus.device_rdata_i[d] = '0; bus.device_err_i[d] = 1'b0;
    end
  endtask

  task automatic hreq(input int h, input logic [31:0] a);
    bus.host_req_i[h] = 1'b1; bus.host_addr_i[h] = a; bus.host_be_i[h] = 4'hF;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [2:0] exp_g;
    int         prev;
    base[0] = 32'h0000_0000; mask[0] = 32'hFFFF_0000;
    base[1] = 32'h0002_0000; mask[1] = 32'hFFFF_0000;
    rst_i = 1'b1;
    idle();
    for (int h = 0; h < 3; h++) hreq(h, 32'h100);
    bus.device_rvalid_i[0] = 1'b1;
    #3;
    chk("rst_gnt", gnt_v(), 0);
    chk("rst_dreq", dreq_v(), 0);
    chk("rst_rvalid", rv_v(), 0);
    tick(); tick();
    chk("rst_outstanding", outstanding, 0);
    chk("rst_perr", perr, 0);
    rst_i = 1'b0;
    idle();

    // All three hosts hammer the RAM, which answers one cycle later.
    prev = 0;
    for (int k = 0; k < 7; k++) begin
      tick(); idle();
      if (k < 6) for (int h = 0; h < 3; h++) hreq(h, 32'h100);
      bus.device_rvalid_i[0] = (k > 0);
      bus.device_rdata_i[0]  = 32'hA000 + k;
      #3;
`ifdef BUS_RR_XBAR_RR_ARB_EN
      exp_g = (k < 6) ? 3'(1 << (k % 3)) : 3'b000;
`else
      exp_g = (k < 6) ? 3'b001 : 3'b000;
`endif
      chk($sformatf("arb_gnt%0d", k), gnt_v(), exp_g);
      chk($sformatf("arb_dreq%0d", k), dreq_v(), (k < 6) ? 2'b01 : 2'b00);
      chk($sformatf("arb_out%0d", k), outstanding, (k > 0) ? 1 : 0);
      if (k > 0) begin
        chk($sformatf("arb_rv%0d", k), rv_v(), 3'(1 << prev));
        chk($sformatf("arb_rdata%0d", k), bus.host_rdata_o[prev], 32'hA000 + k);
      end
      for (int h = 0; h < 3; h++) if (exp_g[h]) prev = h;
    end
    tick(); idle(); #3;
    chk("arb_drained", outstanding, 0);

    // Unmapped address: immediate decode-error response.
    tick(); idle(); hreq(1, 32'h30000); #3;
    chk("dec_gnt", gnt_v(), 3'b010);
    chk("dec_dreq", dreq_v(), 0);
    tick(); idle(); #3;
    chk("dec_rv", rv_v(), 3'b010);
    chk("dec_err", bus.host_err_o[1], 1);
    chk("dec_rdata", bus.host_rdata_o[1], 0);
    chk("dec_gnt_idle", gnt_v(), 0);
    tick(); idle(); #3;
    chk("dec_out", outstanding, 0);

    // Overlapping windows: device 0 must win.
    tick(); idle(); base[1] = 32'h0; hreq(0, 32'h104); #3;
    chk("ovl_dreq", dreq_v(), 2'b01);
    tick(); idle(); base[1] = 32'h0002_0000; bus.device_rvalid_i[0] = 1'b1; #3;
    chk("ovl_rv", rv_v(), 3'b001);

    // Silent device: fill to capacity, then a retire lets a grant through.
    for (int k = 0; k < 6; k++) begin
      tick(); idle(); hreq(0, 32'h100);
      bus.device_rvalid_i[0] = (k == 5);
      bus.device_rdata_i[0]  = 32'h55;
      #3;
      chk($sformatf("full_gnt%0d", k), bus.host_gnt_o[0], (k != 4));
      chk($sformatf("full_out%0d", k), outstanding, (k < 4) ? k : 4);
      if (k == 4) chk("full_dreq", dreq_v(), 0);
      if (k == 5) chk("full_rv", rv_v(), 3'b001);
    end
    for (int i = 0; i < 4; i++) begin
      tick(); idle(); bus.device_rvalid_i[0] = 1'b1; #3;
      if (i == 0) chk("full_hold", outstanding, 4);
      chk($sformatf("full_drain_rv%0d", i), rv_v(), 3'b001);
    end
    tick(); idle(); #3;
    chk("full_empty", outstanding, 0);

    // Out-of-order device response is dropped and flagged.
    tick(); idle(); hreq(0, 32'h100); #3;
    chk("ooo_dreq0", dreq_v(), 2'b01);
    tick(); idle(); hreq(2, 32'h20004); #3;
    chk("ooo_dreq1", dreq_v(), 2'b10);
    chk("ooo_addr1", bus.device_addr_o[1], 32'h20004);
    chk("ooo_gnt", gnt_v(), 3'b100);
    tick(); idle(); bus.device_rvalid_i[1] = 1'b1; bus.device_rdata_i[1] = 32'hBAD; #3;
    chk("ooo_rv_drop", rv_v(), 0);
    chk("ooo_out", outstanding, 2);
    tick(); idle(); #3;
    chk("ooo_perr", perr, 1);
    chk("ooo_out_kept", outstanding, 2);
    tick(); idle(); bus.device_rvalid_i[0] = 1'b1; bus.device_rdata_i[0] = 32'h11; #3;
    chk("ooo_rv0", rv_v(), 3'b001);
    chk("ooo_rdata0", bus.host_rdata_o[0], 32'h11);
    tick(); idle(); bus.device_rvalid_i[1] = 1'b1; bus.device_rdata_i[1] = 32'h22;
    bus.device_err_i[1] = 1'b1; #3;
    chk("ooo_rv2", rv_v(), 3'b100);
    chk("ooo_rdata2", bus.host_rdata_o[2], 32'h22);
    chk("ooo_err2", bus.host_err_o[2], 1);
    chk("ooo_rdata_other", bus.host_rdata_o[0], 0);
    tick(); idle(); #3;
    chk("ooo_empty", outstanding, 0);

    // Reset with three requests in flight.
    for (int k = 0; k < 3; k++) begin
      tick(); idle(); hreq(0, 32'h100);
    end
    tick(); idle(); rst_i = 1'b1;
    for (int h = 0; h < 3; h++) hreq(h, 32'h100);
    bus.device_rvalid_i[0] = 1'b1; #3;
    chk("mrst_out_pre", outstanding, 3);
    chk("mrst_gnt", gnt_v(), 0);
    chk("mrst_rv", rv_v(), 0);
    chk("mrst_dreq", dreq_v(), 0);
    tick(); rst_i = 1'b0; idle(); #3;
    chk("mrst_out", outstanding, 0);
    chk("mrst_perr", perr, 0);
    tick(); idle(); bus.device_rvalid_i[0] = 1'b1; #3;
    chk("late_rv", rv_v(), 0);
    tick(); idle(); #3;
    chk("late_perr", perr, 1);
    chk("late_out", outstanding, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
